// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
//   Shared constants for the FIFO-to-UART drain path (TX now, RX later).
//   - FSM state encodings for the transmitter
//   - BITS_PER_BYTE
//   - width helpers for the byte index and the bit timer
package fifo_uart_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_START   = 3'd3;
    localparam logic [2:0] ST_DATA    = 3'd4;
    localparam logic [2:0] ST_PARITY  = 3'd5;
    localparam logic [2:0] ST_STOP    = 3'd6;

    // Width of the byte index for a word of data_width bits; never below 1.
    function automatic int byte_idx_width(input int data_width);
        int n;
        n = data_width / BITS_PER_BYTE;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the bit timer counting 0..clks_per_bit-1; never below 1.
    function automatic int timer_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// uart_bit_timer
//   Free-running bit-period counter, 0..CLKS_PER_BIT-1 with wrap.
//   Ports:
//     clk      system clock
//     rst_n    asynchronous active-low reset
//     clear    holds the count at 0 (used while no frame is on the line)
//     bit_done one-cycle pulse while the count sits at CLKS_PER_BIT-1
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int TW = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_COUNT = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear || (count_reg == LAST_COUNT)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bit_done = !clear && (count_reg == LAST_COUNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains fifo_sync and serialises each DATA_WIDTH-bit word as DATA_WIDTH/8
//   UART frames (1 start, 8 data LSB first, [even parity], 1 stop), least
//   significant byte first.
//   Optional feature macro: FIFO_UART_TX_PARITY_EN (adds the even-parity bit).
//   Ports:
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     enable      permits fetching a new word (looked at only in IDLE)
//     fifo_empty  fifo_sync empty flag
//     fifo_data   fifo_sync data_out (valid one cycle after the pop edge)
//     fifo_cs     chip-select to fifo_sync, mirrors fifo_rd_en
//     fifo_rd_en  one-cycle pop request
//     tx          UART line, idle high
//     busy        high from pop request until the last stop bit ends
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int NUM_BYTES = DATA_WIDTH / BITS_PER_BYTE;
    localparam int BIW       = byte_idx_width(DATA_WIDTH);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(NUM_BYTES - 1);
    localparam logic [2:0]     LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    uart_state_t           state_reg;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [2:0]            bit_cnt_reg;
    logic [BIW-1:0]        byte_idx_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  rd_en_reg;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_reg;
`endif
    logic                  timer_clear;
    logic                  bit_done;

    // The timer only runs while a frame is on the line, so the first START
    // period begins at a clean count of 0.
    assign timer_clear = (state_reg == ST_IDLE) || (state_reg == ST_REQ) ||
                         (state_reg == ST_CAPTURE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            word_reg     <= '0;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            rd_en_reg    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        state_reg <= ST_REQ;
                        rd_en_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // fifo_sync pops on this edge; its data appears next cycle.
                    rd_en_reg <= 1'b0;
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    word_reg     <= fifo_data;
                    byte_idx_reg <= '0;
                    bit_cnt_reg  <= '0;
                    tx_reg       <= 1'b0;
                    state_reg    <= ST_START;
                end
                ST_START: begin
                    if (bit_done) begin
                        tx_reg    <= word_reg[0];
                        state_reg <= ST_DATA;
`ifdef FIFO_UART_TX_PARITY_EN
                        parity_reg <= ^word_reg[BITS_PER_BYTE-1:0];
`endif
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        // The whole word shifts, so after 8 shifts the next
                        // byte already sits in the low bits.
                        word_reg <= word_reg >> 1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_reg <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= ST_PARITY;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            tx_reg      <= word_reg[1];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        tx_reg    <= 1'b1;
                        state_reg <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_done) begin
                        if (byte_idx_reg != LAST_BYTE) begin
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            tx_reg       <= 1'b0;
                            state_reg    <= ST_START;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    rd_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_reg;
    assign fifo_cs    = rd_en_reg;
    assign tx         = tx_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Drives fifo_uart_tx from a small behavioural model of fifo_sync (depth 8,
//   registered read) and decodes the tx line with a bit-centre UART monitor.
//   Expected bytes come from a hand-written vector table and are queued when
//   a word is written; the monitor pops and compares each decoded byte.
//   Build with +define+FIFO_UART_TX_PARITY_EN to exercise the parity frame.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int BYTE_CYC = FRAME_BITS * CPB;
    localparam int WORD_CYC = 4 * BYTE_CYC;
    localparam int DEPTH    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_full = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_cs, fifo_rd_en, tx, busy;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] fq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, pops = 0, rd_long = 0, cs_bad = 0, busy_cyc = 0;
    bit rd_prev = 1'b0, tx_low_seen = 1'b0;
    int rise_q[$];
    int start_q[$];
    logic [8:0] exp_q[$];

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;   // expected bytes in line order
    } vec_t;
    vec_t vecs[15];

    fifo_uart_tx #(
        .DATA_WIDTH  (32),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_cs   (fifo_cs),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // fifo_sync model: pop on rd_en & cs, data registered one cycle later.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_cs && fq.size() != 0) fifo_data <= fq.pop_front();
        if (wr_en && fq.size() < DEPTH) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
        fifo_full  <= (fq.size() == DEPTH);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Activity monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) begin
                if (!rd_prev) begin
                    pops++;
                    rise_q.push_back(cyc);
                end else begin
                    rd_long++;
                end
            end
            if (fifo_cs !== fifo_rd_en) cs_bad++;
            if (busy) busy_cyc++;
            if (tx === 1'b0) tx_low_seen = 1'b1;
        end
        rd_prev = fifo_rd_en;
    end

    // UART decoder, sampling each bit at its centre
    int         mon_cnt = 0;
    int         mon_k = 0;
    bit         mon_act = 1'b0;
    logic [7:0] mon_byte = '0;
    logic       mon_par = 1'b0;
    logic [8:0] mon_exp = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
        end
        if (rst_n && mon_act && (mon_cnt % CPB) == CPB / 2) begin
            mon_k = mon_cnt / CPB;
            if (mon_k == 0) begin
                check("start_bit", tx, 1'b0);
            end else if (mon_k <= 8) begin
                mon_byte[mon_k-1] = tx;
            end else if (mon_k < FRAME_BITS - 1) begin
                mon_par = tx;
            end else begin
                check("stop_bit", tx, 1'b1);
                check("byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("byte", mon_byte, mon_exp[7:0]);
`ifdef FIFO_UART_TX_PARITY_EN
                    check("parity", mon_par, mon_exp[8]);
`endif
                    $display("byte 0x%02h decoded, want 0x%02h", mon_byte, mon_exp[7:0]);
                end
                mon_act = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] w);
        wr_data = w;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic expect_vec(input int i);
        exp_q.push_back({^vecs[i].b0, vecs[i].b0});
        exp_q.push_back({^vecs[i].b1, vecs[i].b1});
        exp_q.push_back({^vecs[i].b2, vecs[i].b2});
        exp_q.push_back({^vecs[i].b3, vecs[i].b3});
    endtask

    task automatic wait_until_idle(input int max, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(!busy && fifo_empty && !fifo_rd_en) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < max, 1'b1);
    endtask

    task automatic wait_not_busy(input int max, input string name);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < max, 1'b1);
    endtask

    task automatic wait_pop(input int max, input string name);
        int n;
        n = 0;
        while (!fifo_rd_en && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < max, 1'b1);
    endtask

    task automatic wait_start(input int s0, input int max, input string name);
        int n;
        n = 0;
        while (start_q.size() <= s0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, n < max, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, r0, s0, b0;

        vecs[0]  = '{32'h44332211, 8'h11, 8'h22, 8'h33, 8'h44};
        vecs[1]  = '{32'h00000001, 8'h01, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{32'h0000000A, 8'h0A, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{32'h00000064, 8'h64, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        vecs[5]  = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};
        vecs[6]  = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[8]  = '{32'hA5A55A5A, 8'h5A, 8'h5A, 8'hA5, 8'hA5};
        vecs[9]  = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80};
        vecs[10] = '{32'h0F0F0F0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
        vecs[11] = '{32'h00C0FFEE, 8'hEE, 8'hFF, 8'hC0, 8'h00};
        vecs[12] = '{32'h3C2B1A09, 8'h09, 8'h1A, 8'h2B, 8'h3C};
        vecs[13] = '{32'h77665544, 8'h44, 8'h55, 8'h66, 8'h77};
        vecs[14] = '{32'h00000007, 8'h07, 8'h00, 8'h00, 8'h00};

        // Reset values
        tick(3);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_rd_en", fifo_rd_en, 1'b0);
        check("reset_cs", fifo_cs, 1'b0);
        rst_n = 1'b1;
        tick(20);
        check("idle_busy", busy, 1'b0);
        check("idle_tx", tx, 1'b1);
        check("idle_pops", pops, 0);

        // Single word
        enable = 1'b1;
        p0 = pops; r0 = rise_q.size(); s0 = start_q.size(); b0 = busy_cyc;
        expect_vec(0);
        write_word(vecs[0].word);
        wait_until_idle(WORD_CYC + 50, "single");
        check("single_pops", pops - p0, 1);
        check("single_starts", start_q.size() - s0, 4);
        if (rise_q.size() > r0 && start_q.size() > s0 + 1) begin
            check("single_latency", start_q[s0] - rise_q[r0], 2);
            check("byte_spacing", start_q[s0+1] - start_q[s0], BYTE_CYC);
        end
        check("single_busy_cycles", busy_cyc - b0, WORD_CYC + 2);
        check("single_empty_after", fifo_empty, 1'b1);

        // Back-to-back words
        p0 = pops; r0 = rise_q.size();
        for (int i = 1; i <= 3; i++) expect_vec(i);
        for (int i = 1; i <= 3; i++) write_word(vecs[i].word);
        wait_until_idle(3 * (WORD_CYC + 10), "b2b");
        check("b2b_pops", pops - p0, 3);
        if (rise_q.size() >= r0 + 3) begin
            check("b2b_gap_1", rise_q[r0+1] - rise_q[r0], WORD_CYC + 3);
            check("b2b_gap_2", rise_q[r0+2] - rise_q[r0+1], WORD_CYC + 3);
        end

        // enable gating with a full FIFO
        enable = 1'b0;
        for (int i = 4; i <= 11; i++) begin
            expect_vec(i);
            write_word(vecs[i].word);
        end
        tick(1);
        check("gate_full", fifo_full, 1'b1);
        p0 = pops;
        tx_low_seen = 1'b0;
        tick(500);
        check("gate_no_pop", pops - p0, 0);
        check("gate_tx_idle", tx_low_seen, 1'b0);
        enable = 1'b1;
        wait_pop(20, "gate_first_pop");
        tick(2);
        check("gate_full_drops", fifo_full, 1'b0);
        wait_until_idle(DEPTH * (WORD_CYC + 10), "gate_drain");
        check("gate_pops", pops - p0, DEPTH);

        // enable dropped mid-word
        p0 = pops;
        expect_vec(12);
        write_word(vecs[12].word);
        write_word(vecs[13].word);
        wait_pop(10, "midword_pop");
        tick(40);
        enable = 1'b0;
        wait_not_busy(WORD_CYC + 10, "midword_finish");
        tick(50);
        check("midword_pops", pops - p0, 1);
        check("midword_left", fq.size(), 1);
        check("midword_busy", busy, 1'b0);
        enable = 1'b1;
        expect_vec(13);
        wait_until_idle(WORD_CYC + 20, "midword_resume");
        check("midword_resume_pops", pops - p0, 2);

        // Parity sample word (also plain 8N1 timing without the macro)
        s0 = start_q.size();
        expect_vec(14);
        write_word(vecs[14].word);
        wait_until_idle(WORD_CYC + 20, "word7");
        if (start_q.size() > s0 + 2)
            check("word7_spacing", start_q[s0+2] - start_q[s0+1], BYTE_CYC);

        // Reset mid-frame: the popped word is dropped
        p0 = pops; s0 = start_q.size();
        write_word(32'hCAFEF00D);
        wait_start(s0, 20, "abort_start");
        tick(25);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_rd_en", fifo_rd_en, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("abort_idle_busy", busy, 1'b0);
        check("abort_idle_tx", tx, 1'b1);
        check("abort_pops", pops - p0, 1);
        check("abort_fifo_empty", fq.size(), 0);

        // Global properties
        check("scoreboard_drained", exp_q.size(), 0);
        check("rd_en_single_cycle", rd_long, 0);
        check("cs_tracks_rd_en", cs_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for fifo_sync. Pops DATA_WIDTH-bit words from the FIFO whenever it is non-empty and enabled. Serialises each word onto a UART TX line as DATA_WIDTH/8 byte frames, least-significant byte first. Gives the FIFO a real consumer for board-level loopback and debug output.

Parameters:
DATA_WIDTH, 32, FIFO word width; must be a multiple of 8.
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permits fetching a new word; sampled only in IDLE
fifo_empty  input  1  fifo_sync empty flag
fifo_data  input  DATA_WIDTH  fifo_sync data_out
fifo_cs  output  1  chip-select to fifo_sync, high with fifo_rd_en
fifo_rd_en  output  1  one-cycle pop request to fifo_sync
tx  output  1  UART serial line, idle high
busy  output  1  high from pop request until last stop bit ends

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, fifo_rd_en=0, fifo_cs=0, state=IDLE, all counters 0. Reset mid-frame aborts the frame immediately. The popped word is lost.
- All outputs are registered.
- States: IDLE, REQ, CAPTURE, START, DATA, [PARITY], STOP.
- IDLE: on a clk edge with enable=1 and fifo_empty=0, go to REQ. fifo_rd_en, fifo_cs and busy are set to 1.
- REQ: lasts exactly one cycle. fifo_rd_en and fifo_cs drop to 0 on exit. The FIFO pops on this edge.
- CAPTURE: fifo_data is valid one cycle after the pop edge. Latch it into the shift word, set byte_idx=0, drive tx=0, go to START.
- Latency: 2 clk edges from fifo_rd_en rising to tx falling.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits of the current byte, LSB first, CLKS_PER_BIT cycles each.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte_idx < DATA_WIDTH/8-1: increment byte_idx and go to START. There is no idle gap between bytes of one word.
  - else: go to IDLE with busy=0.
- Back-to-back words: IDLE re-evaluates on the next edge, so there is a one-cycle idle-high gap plus 2 fetch cycles between words.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. Width is $clog2(CLKS_PER_BIT).
- Bit counter: 3 bits, 0..7.
- byte_idx width: $clog2(DATA_WIDTH/8), minimum 1.
- enable deasserted mid-word: the current word always completes. enable only gates the next fetch.
- fifo_empty is never sampled outside IDLE. No pop is ever issued while fifo_empty=1, so no underflow is possible.
- Total time per word: (DATA_WIDTH/8) × 10 × CLKS_PER_BIT cycles (11× with parity).

Optional Feature:
FIFO_UART_TX_PARITY_EN
- Defined: PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bits.
- Undefined: PARITY state and its logic are absent. Frame is 10 bits (8N1).

Decomposition:
- Package fifo_uart_pkg:
  - state enum (IDLE, REQ, CAPTURE, START, DATA, PARITY, STOP)
  - BITS_PER_BYTE=8
  - localparam function for byte-count and timer widths
- Sub-module uart_bit_timer:
  - parameter CLKS_PER_BIT; inputs clk, rst_n, clear
  - output bit_done: one-cycle pulse at count CLKS_PER_BIT-1
  - reused by the planned RX block.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DATA_WIDTH=32, and fifo_sync instantiated in the bench.
1. Reset check: rst_n=0 → tx=1, busy=0, fifo_rd_en=0. Pulse rst_n low at cycle 25 of a frame → tx=1 within the same cycle. After release the block stays in IDLE if the FIFO is empty.
2. Single word: write 0x44332211, enable=1.
   - Expect exactly one fifo_rd_en pulse.
   - tx falls 2 edges later.
   - Decoded bytes: 0x11, 0x22, 0x33, 0x44. First byte bits are 1,0,0,0,1,0,0,0.
   - busy high for 2+160 cycles.
   - empty=1 afterwards.
3. Back-to-back: write 1, 10, 100 → three words decoded in order with no extra pops. fifo_rd_en pulses are 163 cycles apart.
4. enable gating: fill FIFO with 8 words (full=1), enable=0.
   - No pops and tx stays 1 for 500 cycles.
   - Raise enable → all 8 words drain in order. full drops after the first pop.
5. enable dropped mid-word (cycle 40 of a word) → the word finishes all 4 bytes and no further pop occurs.
6. With FIFO_UART_TX_PARITY_EN: word 0x00000007 → first byte's parity bit = 1, remaining bytes' parity = 0. Frame is 44 cycles per byte.
